// File: rtl/dup_range_param_if.sv
// dup_range_param_if
//   Generator-protocol bundle between a dup_range_param generator and its
//   consumer. The master side (consumer) drives the start request, the range
//   arguments and _ready. The slave side (generator) drives _valid, _done and
//   the tuple outputs _0 (range value) and _1 (copy index).
// Parameters
//   WIDTH  signed width of base/limit/step/_0
//   CNT_W  width of repeat_count/_1
interface dup_range_param_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic                    _start;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic        [CNT_W-1:0] repeat_count;
  logic                    _ready;
  logic                    _valid;
  logic                    _done;
  logic signed [WIDTH-1:0] _0;
  logic        [CNT_W-1:0] _1;

  modport master (
    output _start, base, limit, step, repeat_count, _ready,
    input  _valid, _done, _0, _1
  );

  modport slave (
    input  _start, base, limit, step, repeat_count, _ready,
    output _valid, _done, _0, _1
  );
endinterface

// File: rtl/dup_range_param.sv
// dup_range_param
//   Streams range(base, limit, step) with every value repeated repeat_count
//   times. Each beat carries the value on _0 and its copy index on _1.
//   The range arguments are captured on _start, and generation (re)starts
//   from there. A beat held by a stalled consumer stays stable.
//   Stepping past the signed WIDTH range ends the stream instead of wrapping.
// Ports
//   _clock  sole clock, rising edge
//   _reset  asynchronous, active-low reset
//   bus     generator-protocol slave (see dup_range_param_if)
module dup_range_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic              _clock,
  input  logic              _reset,
  dup_range_param_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] cur_q,   cur_d;
  logic signed [WIDTH-1:0] lim_q,   lim_d;
  logic signed [WIDTH-1:0] stp_q,   stp_d;
  logic        [CNT_W-1:0] cnt_q,   cnt_d;
  logic        [CNT_W-1:0] rep_q,   rep_d;
  logic                    exh_q,   exh_d;
  logic                    valid_q, valid_d;
  logic                    done_q,  done_d;
  logic signed [WIDTH-1:0] out0_q,  out0_d;
  logic        [CNT_W-1:0] out1_q,  out1_d;

  logic             adv;
  logic             arg_step_zero;
  logic             arg_step_pos;
  logic             arg_in_range;
  logic             stp_pos;
  logic             cur_in_range;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  // The output register may be reloaded when it is empty or being consumed.
  assign adv = bus._ready || !valid_q;

  // Range test on the raw start arguments, used to detect an empty stream.
  assign arg_step_zero = (bus.step == '0);
  assign arg_step_pos  = !bus.step[WIDTH-1] && !arg_step_zero;
  assign arg_in_range  = arg_step_pos ? (bus.base < bus.limit)
                                      : (bus.base > bus.limit);

  // Range test on the running value; step is never zero once running.
  assign stp_pos      = !stp_q[WIDTH-1];
  assign cur_in_range = stp_pos ? (cur_q < lim_q) : (cur_q > lim_q);

  // Sign-extended add: the top two bits disagree exactly when the next
  // value would not fit in WIDTH signed bits.
  assign sum     = {cur_q[WIDTH-1], cur_q} + {stp_q[WIDTH-1], stp_q};
  assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];

  // NOTE: every next-state signal is defaulted to its current value before
  // any branch, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lim_d   = lim_q;
    stp_d   = stp_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    exh_d   = exh_q;
    valid_d = valid_q;
    done_d  = done_q;
    out0_d  = out0_q;
    out1_d  = out1_q;

    if (bus._start) begin
      // A restart discards any beat still waiting for the consumer.
      cur_d   = bus.base;
      lim_d   = bus.limit;
      stp_d   = bus.step;
      cnt_d   = bus.repeat_count;
      rep_d   = '0;
      exh_d   = 1'b0;
      valid_d = 1'b0;
      if (arg_step_zero || (bus.repeat_count == '0) || !arg_in_range) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
        RUN: begin
          if (adv) begin
            if (!exh_q && cur_in_range) begin
              out0_d  = cur_q;
              out1_d  = rep_q;
              valid_d = 1'b1;
              if (rep_q == cnt_q - CNT_W'(1)) begin
                rep_d = '0;
                // On overflow the value is frozen and the stream closes
                // on the next advance, after this last copy is taken.
                if (sum_ovf) begin
                  exh_d = 1'b1;
                end else begin
                  cur_d = sum[WIDTH-1:0];
                end
              end else begin
                rep_d = rep_q + CNT_W'(1);
              end
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values of the combinational block.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      lim_q   <= '0;
      stp_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      exh_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      stp_q   <= stp_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      exh_q   <= exh_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
    end
  end

  assign bus._valid = valid_q;
  assign bus._done  = done_q;
  assign bus._0     = out0_q;
  assign bus._1     = out1_q;

endmodule

// File: tb/tb_dup_range_param.sv
// tb_dup_range_param
//   Directed bench for dup_range_param: a 32-bit instance for the functional
//   scenarios and an 8-bit instance for the no-wrap end of range. Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_dup_range_param;

  logic clk;
  logic rst_n;

  dup_range_param_if #(.WIDTH(32), .CNT_W(8)) bus  ();
  dup_range_param_if #(.WIDTH(8),  .CNT_W(8)) bus8 ();

  dup_range_param #(.WIDTH(32), .CNT_W(8)) dut (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus)
  );

  dup_range_param #(.WIDTH(8), .CNT_W(8)) dut8 (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] got0[$];
  logic        [7:0]  got1[$];
  int first_idx, last_idx, done_idx, stall_err, n_stalls;

  // Caller sits just after a falling edge; returns one falling edge later,
  // i.e. just after the rising edge that sampled _start.
  task automatic start(input int b, input int l, input int s, input int r, input bit rdy);
    bus.base         = b;
    bus.limit        = l;
    bus.step         = s;
    bus.repeat_count = r[7:0];
    bus._ready       = rdy;
    bus._start       = 1'b1;
    @(negedge clk);
    bus._start       = 1'b0;
  endtask

  // Consumes beats until _done or the cycle budget runs out. With toggle set,
  // _ready alternates and any change of a held beat is counted in stall_err.
  task automatic collect(input bit toggle, input int budget);
    bit                 held;
    logic signed [31:0] h0;
    logic        [7:0]  h1;
    got0.delete();
    got1.delete();
    first_idx = -1; last_idx = -1; done_idx = -1;
    stall_err = 0;  n_stalls = 0;  held = 1'b0;
    h0 = '0; h1 = '0;
    for (int i = 0; i < budget; i++) begin
      if (bus._done) begin
        done_idx = i;
        break;
      end
      bus._ready = toggle ? (i % 2 == 1) : 1'b1;
      if (held && (!bus._valid || bus._0 !== h0 || bus._1 !== h1)) stall_err++;
      held = bus._valid && !bus._ready;
      if (held) n_stalls++;
      h0 = bus._0;
      h1 = bus._1;
      if (bus._valid && bus._ready) begin
        got0.push_back(bus._0);
        got1.push_back(bus._1);
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus._valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus._valid); end
    checks++; if (bus._done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus._done); end
    checks++; if (bus._0 !== 32'sd0 || bus._1 !== 8'd0) begin failures++; $display("FAIL reset_outputs got=%0d/%0d exp=0/0", bus._0, bus._1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus._done !== 1'b1 || bus._valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle done=%b valid=%b exp done=1 valid=0", bus._done, bus._valid); end
  endtask

  task automatic test_basic();
    int e0[$] = '{0, 0, 2, 2, 4, 4, 6, 6, 8, 8};
    start(0, 10, 2, 2, 1'b1);
    checks++; if (bus._valid !== 1'b0 || bus._done !== 1'b0) begin failures++; $display("FAIL basic_after_start valid=%b done=%b exp 0/0", bus._valid, bus._done); end
    collect(1'b0, 40);
    checks++; if (done_idx < 0) begin failures++; $display("FAIL basic_timeout done never seen"); end
    checks++; if (first_idx !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", first_idx); end
    checks++; if (got0.size() !== e0.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got0.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== e0[i] || got1[i] !== 8'(i % 2)) begin
        failures++; $display("FAIL basic_beat%0d got=%0d/%0d exp=%0d/%0d", i, got0[i], got1[i], e0[i], i % 2);
      end
    end
    checks++; if (done_idx - last_idx !== 1 || bus._valid !== 1'b0) begin failures++; $display("FAIL basic_end_edge gap=%0d valid=%b exp gap=1 valid=0", done_idx - last_idx, bus._valid); end
  endtask

  task automatic test_negative_step();
    int e0[$] = '{5, 5, 5, 3, 3, 3, 1, 1, 1};
    start(5, -1, -2, 3, 1'b1);
    collect(1'b0, 40);
    checks++; if (done_idx < 0 || got0.size() !== e0.size()) begin failures++; $display("FAIL neg_count got=%0d exp=%0d done_idx=%0d", got0.size(), e0.size(), done_idx); end
    for (int i = 0; i < e0.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== e0[i] || got1[i] !== 8'(i % 3)) begin
        failures++; $display("FAIL neg_beat%0d got=%0d/%0d exp=%0d/%0d", i, got0[i], got1[i], e0[i], i % 3);
      end
    end
  endtask

  task automatic test_empty();
    int vb[3] = '{0, 0, 10};
    int vl[3] = '{10, 10, 10};
    int vs[3] = '{0, 1, 1};
    int vr[3] = '{2, 0, 1};
    for (int c = 0; c < 3; c++) begin
      start(vb[c], vl[c], vs[c], vr[c], 1'b1);
      checks++; if (bus._valid !== 1'b0) begin failures++; $display("FAIL empty%0d_valid_k got=%b exp=0", c, bus._valid); end
      @(negedge clk);
      checks++; if (bus._done !== 1'b1 || bus._valid !== 1'b0) begin failures++; $display("FAIL empty%0d_done done=%b valid=%b exp 1/0", c, bus._done, bus._valid); end
    end
  endtask

  task automatic test_stall();
    int e0[$] = '{0, 0, 3, 3};
    start(0, 6, 3, 2, 1'b0);
    collect(1'b1, 40);
    checks++; if (stall_err !== 0 || n_stalls == 0) begin failures++; $display("FAIL stall_stable changes=%0d stalls=%0d exp changes=0 stalls>0", stall_err, n_stalls); end
    checks++; if (done_idx < 0 || got0.size() !== e0.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got0.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== e0[i] || got1[i] !== 8'(i % 2)) begin
        failures++; $display("FAIL stall_beat%0d got=%0d/%0d exp=%0d/%0d", i, got0[i], got1[i], e0[i], i % 2);
      end
    end
  endtask

  task automatic test_overflow();
    logic signed [7:0] g[$];
    logic signed [7:0] e[$] = '{8'sd120, 8'sd125};
    bit finished = 1'b0;
    bus8.base = 8'sd120; bus8.limit = 8'sd127; bus8.step = 8'sd5;
    bus8.repeat_count = 8'd1; bus8._ready = 1'b1; bus8._start = 1'b1;
    @(negedge clk);
    bus8._start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus8._done) begin finished = 1'b1; break; end
      if (bus8._valid) g.push_back(bus8._0);
      @(negedge clk);
    end
    checks++; if (!finished || g.size() !== 2) begin failures++; $display("FAIL ovf_count got=%0d exp=2 finished=%b", g.size(), finished); end
    for (int i = 0; i < 2 && i < g.size(); i++) begin
      checks++; if (g[i] !== e[i]) begin failures++; $display("FAIL ovf_beat%0d got=%0d exp=%0d", i, g[i], e[i]); end
    end
  endtask

  task automatic test_restart();
    start(0, 10, 1, 1, 1'b0);
    @(negedge clk);
    checks++; if (bus._valid !== 1'b1 || bus._0 !== 32'sd0) begin failures++; $display("FAIL restart_pending valid=%b val=%0d exp 1/0", bus._valid, bus._0); end
    start(100, 102, 1, 1, 1'b0);
    checks++; if (bus._valid !== 1'b0 || bus._done !== 1'b0) begin failures++; $display("FAIL restart_drop valid=%b done=%b exp 0/0", bus._valid, bus._done); end
    collect(1'b0, 20);
    checks++; if (done_idx < 0 || got0.size() !== 2) begin failures++; $display("FAIL restart_count got=%0d exp=2", got0.size()); end
    if (got0.size() == 2) begin
      checks++; if (got0[0] !== 32'sd100 || got0[1] !== 32'sd101 || got1[0] !== 8'd0 || got1[1] !== 8'd0) begin
        failures++; $display("FAIL restart_values got=%0d,%0d exp=100,101", got0[0], got0[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    start(0, 10, 1, 1, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (bus._valid !== 1'b1) begin failures++; $display("FAIL areset_pre valid=%b exp=1", bus._valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus._valid !== 1'b0 || bus._done !== 1'b0 || bus._0 !== 32'sd0) begin
      failures++; $display("FAIL areset_immediate valid=%b done=%b val=%0d exp 0/0/0", bus._valid, bus._done, bus._0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus._done !== 1'b1 || bus._valid !== 1'b0) begin failures++; $display("FAIL areset_release done=%b valid=%b exp 1/0", bus._done, bus._valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus._start  = 1'b0; bus.base  = '0; bus.limit  = '0; bus.step  = '0; bus.repeat_count  = '0; bus._ready  = 1'b0;
    bus8._start = 1'b0; bus8.base = '0; bus8.limit = '0; bus8.step = '0; bus8.repeat_count = '0; bus8._ready = 1'b0;
    test_reset();
    test_basic();
    test_negative_step();
    test_empty();
    test_stall();
    test_overflow();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
